// File: rtl/muldiv.sv
// Iterative multiply/divide unit producing HI/LO for MULT/MULTU/DIV/DIVU.
// Define MULDIV_MACC_EN to enable MADD/MADDU/MSUB/MSUBU.
module muldiv #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_W-1:0]     opA_i,
  input  logic [DATA_W-1:0]     opB_i,
  input  logic [2*DATA_W-1:0]   hiLo_i,
  input  logic                  cancel_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  wHiLo_o,
  output logic [DATA_W-1:0]     hiData_o,
  output logic [DATA_W-1:0]     loData_o,
  output logic                  divZero_o
);

  localparam int unsigned W2    = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_q, state_nxt;
  logic                legal_c, accept_c, is_div_c, b_zero_c, sgn_div_c;
  logic [DATA_W-1:0]   amag_c, bmag_c;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                mul_sgn_q;
  logic [DATA_W-1:0]   quot_q, rem_q, bmag_q;
  logic                qneg_q, rneg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W:0]     rem_sh_c, diff_c;
  logic [DATA_W-1:0]   rem_n_c, quot_n_c, q_fix_c, r_fix_c;
  logic [W2-1:0]       ext_a_c, ext_b_c, prod_c, mul_res_c;

`ifdef MULDIV_MACC_EN
  logic [W2-1:0]       hilo_q;
  logic [1:0]          acc_q;
  assign legal_c = 1'b1;
`else
  logic                unused_hilo;
  assign unused_hilo = ^hiLo_i;
  assign legal_c     = ~op_i[2];
`endif

  // Start decode; busy is combinational so the start cycle stalls too
  assign accept_c  = start_i & legal_c & (state_q == IDLE);
  assign is_div_c  = ~op_i[2] & op_i[1];
  assign b_zero_c  = (opB_i == '0);
  assign sgn_div_c = (op_i == 3'b010);
  assign amag_c    = (sgn_div_c & opA_i[DATA_W-1]) ? -opA_i : opA_i;
  assign bmag_c    = (sgn_div_c & opB_i[DATA_W-1]) ? -opB_i : opB_i;
  assign busy_o    = accept_c | (state_q == MUL) | (state_q == DIV);
  assign wHiLo_o   = done_o;

  // Restoring divider step and final sign fix-up
  assign rem_sh_c = {rem_q, quot_q[DATA_W-1]};
  assign diff_c   = rem_sh_c - {1'b0, bmag_q};
  assign rem_n_c  = diff_c[DATA_W] ? rem_sh_c[DATA_W-1:0] : diff_c[DATA_W-1:0];
  assign quot_n_c = {quot_q[DATA_W-2:0], ~diff_c[DATA_W]};
  assign q_fix_c  = qneg_q ? -quot_n_c : quot_n_c;
  assign r_fix_c  = rneg_q ? -rem_n_c : rem_n_c;

  // Single-cycle product, optionally accumulated onto the captured HI/LO
  assign ext_a_c = mul_sgn_q ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
  assign ext_b_c = mul_sgn_q ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
  assign prod_c  = ext_a_c * ext_b_c;

  always_comb begin
`ifdef MULDIV_MACC_EN
    case (acc_q)
      2'b10:   mul_res_c = hilo_q + prod_c;
      2'b11:   mul_res_c = hilo_q - prod_c;
      default: mul_res_c = prod_c;
    endcase
`else
    mul_res_c = prod_c;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (!is_div_c)     state_nxt = MUL;
          else if (b_zero_c) state_nxt = DONE;
          else               state_nxt = DIV;
        end
      end
      MUL:     state_nxt = DONE;
      DIV:     if (cnt_q == CNT_W'(DATA_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cancel_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_o    <= 1'b0;
      hiData_o  <= '0;
      loData_o  <= '0;
      divZero_o <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mul_sgn_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      bmag_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef MULDIV_MACC_EN
      hilo_q    <= '0;
      acc_q     <= '0;
`endif
    end else begin
      done_o <= (state_nxt == DONE);
      if (accept_c && !cancel_i) begin
        a_q       <= opA_i;
        b_q       <= opB_i;
        mul_sgn_q <= ~op_i[0];
        quot_q    <= amag_c;
        rem_q     <= '0;
        bmag_q    <= bmag_c;
        qneg_q    <= sgn_div_c & (opA_i[DATA_W-1] ^ opB_i[DATA_W-1]);
        rneg_q    <= sgn_div_c & opA_i[DATA_W-1];
        cnt_q     <= '0;
`ifdef MULDIV_MACC_EN
        hilo_q    <= hiLo_i;
        acc_q     <= op_i[2:1];
`endif
      end
      if (state_q == DIV) begin
        rem_q  <= rem_n_c;
        quot_q <= quot_n_c;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      // Results load only on entry to DONE and hold otherwise
      if (state_nxt == DONE && state_q != DONE) begin
        case (state_q)
          IDLE: begin
            hiData_o  <= '0;
            loData_o  <= '0;
            divZero_o <= 1'b1;
          end
          MUL: begin
            {hiData_o, loData_o} <= mul_res_c;
            divZero_o            <= 1'b0;
          end
          default: begin
            hiData_o  <= r_fix_c;
            loData_o  <= q_fix_c;
            divZero_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: stimulus pushes expected results, a monitor checks on done_o.
module tb_muldiv;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic [2:0]     op_i;
  logic [W-1:0]   opA_i, opB_i;
  logic [2*W-1:0] hiLo_i;
  logic           cancel_i;
  logic           busy_o, done_o, wHiLo_o, divZero_o;
  logic [W-1:0]   hiData_o, loData_o;

  muldiv #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opA_i(opA_i),
    .opB_i(opB_i), .hiLo_i(hiLo_i), .cancel_i(cancel_i), .busy_o(busy_o),
    .done_o(done_o), .wHiLo_o(wHiLo_o), .hiData_o(hiData_o),
    .loData_o(loData_o), .divZero_o(divZero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every completion pulse must match the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done_o) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done_o=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("hi", 64'(hiData_o), 64'(e.hi));
        chk("lo", 64'(loData_o), 64'(e.lo));
        chk("div_zero", 64'(divZero_o), 64'(e.dz));
        chk("whilo", 64'(wHiLo_o), 64'(1));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drive_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] hl, input bit push, input logic [W-1:0] ehi,
                             input logic [W-1:0] elo, input bit edz, input int lat);
    start_i = 1'b1; op_i = op; opA_i = a; opB_i = b; hiLo_i = hl;
    if (push) q.push_back('{ehi, elo, edz, cyc + lat});
    #1 chk("busy_start", 64'(busy_o), 64'(1));
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] hl, input bit push, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input bit edz, input int lat);
    @(negedge clk);
    drive_start(op, a, b, hl, push, ehi, elo, edz, lat);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = '0; opA_i = '0; opB_i = '0; hiLo_i = '0; cancel_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_hi", 64'(hiData_o), 64'(0));
    chk("rst_lo", 64'(loData_o), 64'(0));
    rst = 1'b0;

    // MULT -1 x 2 with busy profile
    do_op(3'b000, 32'hFFFF_FFFF, 32'h2, '0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 2);
    #1 chk("busy_mul", 64'(busy_o), 64'(1));
    @(negedge clk);
    #1 chk("busy_done", 64'(busy_o), 64'(0));
    drain(10);

    do_op(3'b001, 32'hFFFF_FFFF, 32'h2, '0, 1, 32'h0000_0001, 32'hFFFF_FFFE, 0, 2);
    drain(10);
    do_op(3'b010, 32'hFFFF_FFF9, 32'h2, '0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33);
    drain(50);
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1, 32'h0, 32'h8000_0000, 0, 33);
    drain(50);
    do_op(3'b011, 32'd100, 32'd0, '0, 1, 32'h0, 32'h0, 1, 1);
    drain(10);
    do_op(3'b011, 32'd1000, 32'd7, '0, 1, 32'd6, 32'd142, 0, 33);
    drain(50);

    // Flush a divide mid-flight, then start a multiply in the next cycle
    do_op(3'b011, 32'd100, 32'd3, '0, 0, '0, '0, 0, 0);
    repeat (9) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    #1 chk("busy_after_cancel", 64'(busy_o), 64'(0));
    drive_start(3'b001, 32'd3, 32'd4, '0, 1, 32'h0, 32'hC, 0, 2);
    drain(10);

`ifdef MULDIV_MACC_EN
    do_op(3'b100, 32'd3, 32'd4, 64'h5, 1, 32'h0, 32'h11, 0, 2);
    drain(10);
    do_op(3'b111, 32'd1, 32'd6, 64'h0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 2);
    drain(10);
`else
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b100; opA_i = 32'd3; opB_i = 32'd4; hiLo_i = 64'h5;
    #1 chk("macc_illegal_busy", 64'(busy_o), 64'(0));
    @(negedge clk);
    start_i = 1'b0;
    #1 chk("macc_illegal_idle", 64'(busy_o), 64'(0));
    repeat (4) @(negedge clk);
`endif

    // Asynchronous reset in the middle of a divide
    do_op(3'b010, 32'hFFFF_FFF9, 32'h2, '0, 0, '0, '0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_done", 64'(done_o), 64'(0));
    chk("midrst_whilo", 64'(wHiLo_o), 64'(0));
    chk("midrst_dz", 64'(divZero_o), 64'(0));
    chk("midrst_hi", 64'(hiData_o), 64'(0));
    chk("midrst_lo", 64'(loData_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    do_op(3'b000, 32'd7, 32'hFFFF_FFFA, '0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 2);
    drain(10);
    do_op(3'b011, 32'd100, 32'd3, '0, 1, 32'd1, 32'd33, 0, 33);
    drain(50);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
